// File: rtl/pipe_csa_adder_pkg.sv
// Shared constants and helpers for the pipelined conditional-sum add/sub unit.
package csa_pkg;

  localparam int unsigned SEG_DEFAULT = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Number of register stages (and cycles of latency) for an N-bit unit.
  function automatic int unsigned csa_stages(input int unsigned n, input int unsigned seg);
    return n / seg;
  endfunction

endpackage

// File: rtl/pipe_csa_adder_if.sv
// Operand/result stream bundle for pipe_csa_adder (valid/ready on both sides).
interface pipe_csa_adder_if #(
  parameter int unsigned N = 32
) ();

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         co;
  logic         ovf;

  modport master (
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, sum, co, ovf
  );

  modport slave (
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, sum, co, ovf
  );

endinterface

// File: rtl/pipe_csa_adder_seg.sv
// Combinational W-bit conditional-sum segment: both carry-in outcomes are formed
// in parallel and the incoming carry only drives the final select.
module csa_seg #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic [W-1:0] sum,
  output logic         co,
  output logic         c_msb
);

  logic [W:0] res0;
  logic [W:0] res1;

  // Precompute both candidate sums, then select on the carry-in.
  always_comb begin
    res0  = {1'b0, a} + {1'b0, b};
    res1  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
    {co, sum} = ci ? res1 : res0;
    c_msb = sum[W-1] ^ a[W-1] ^ b[W-1];
  end

endmodule

// File: rtl/pipe_csa_adder.sv
// Pipelined N-bit add/sub: one SEG-bit segment is resolved per register stage,
// giving one result per clock with STAGES cycles of latency and per-stage
// valid/ready flow control so bubbles collapse under backpressure.
module pipe_csa_adder
  import csa_pkg::*;
#(
  parameter int unsigned N   = 32,
  parameter int unsigned SEG = SEG_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  pipe_csa_adder_if.slave  bus
);

  localparam int unsigned STAGES = csa_stages(N, SEG);

  if ((N % SEG) != 0) begin : g_bad_width
    $error("pipe_csa_adder: N must be a multiple of SEG");
  end

  logic [N-1:0]    bb;
  logic            c0;
  logic [STAGES:0] rdy;

  // Subtraction is a + ~b + ~ci, so only the B operand and carry are conditioned.
  always_comb begin
    bb = (bus.sub == OP_SUB) ? ~bus.b : bus.b;
    c0 = (bus.sub == OP_SUB) ? ~bus.ci : bus.ci;
  end

  assign rdy[STAGES]  = bus.out_ready;
  assign bus.in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // Operand bits still unresolved on entry to this stage, and low sum bits
    // produced once this stage has registered.
    localparam int unsigned RW = N - k * SEG;
    localparam int unsigned SW = (k + 1) * SEG;

    logic [RW-1:0]  op_a;
    logic [RW-1:0]  op_b;
    logic           cin;
    logic           up_v;
    logic [SW-1:0]  s_next;
    logic [SEG-1:0] seg_sum;
    logic           seg_co;
    logic           seg_msb;
    logic           v_q;
    logic           c_q;
    logic [SW-1:0]  s_q;

    if (k == 0) begin : g_src
      assign op_a   = bus.a;
      assign op_b   = bb;
      assign cin    = c0;
      assign up_v   = bus.in_valid;
      assign s_next = seg_sum;
    end else begin : g_src
      assign op_a   = g_st[k-1].g_rem.a_q;
      assign op_b   = g_st[k-1].g_rem.b_q;
      assign cin    = g_st[k-1].c_q;
      assign up_v   = g_st[k-1].v_q;
      assign s_next = {seg_sum, g_st[k-1].s_q};
    end

    csa_seg #(.W(SEG)) u_seg (
      .a     (op_a[SEG-1:0]),
      .b     (op_b[SEG-1:0]),
      .ci    (cin),
      .sum   (seg_sum),
      .co    (seg_co),
      .c_msb (seg_msb)
    );

    assign rdy[k] = ~v_q | rdy[k+1];

    // Stage register: advances whenever downstream has room; data only moves with a valid.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (rdy[k]) begin
        v_q <= up_v;
        if (up_v) begin
          c_q <= seg_co;
          s_q <= s_next;
        end
      end
    end

    if (k < STAGES - 1) begin : g_rem
      logic [RW-SEG-1:0] a_q;
      logic [RW-SEG-1:0] b_q;

      // Carry the unconsumed high segments of both operands to the next stage.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (rdy[k] && up_v) begin
          a_q <= op_a[RW-1:SEG];
          b_q <= op_b[RW-1:SEG];
        end
      end
    end

    if (k == STAGES - 1) begin : g_top
      logic o_q;

      // Overflow only exists at the top segment: carry into MSB xor carry out.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          o_q <= 1'b0;
        end else if (rdy[k] && up_v) begin
          o_q <= seg_msb ^ seg_co;
        end
      end
    end
  end

  assign bus.out_valid = g_st[STAGES-1].v_q;
  assign bus.sum       = g_st[STAGES-1].s_q;
  assign bus.co        = g_st[STAGES-1].c_q;
  assign bus.ovf       = g_st[STAGES-1].g_top.o_q;

endmodule

// File: tb/tb_pipe_csa_adder.sv
// Self-checking bench for pipe_csa_adder: directed vectors, latency, throughput,
// backpressure, reset-with-traffic and constrained-random streams at three widths.
module tb_pipe_csa_adder;
  import csa_pkg::*;

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sub;
    logic [31:0] sum;
    logic        co;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;

  pipe_csa_adder_if #(.N(32)) bus32 ();
  pipe_csa_adder_if #(.N(16)) bus16 ();
  pipe_csa_adder_if #(.N(12)) bus12 ();

  pipe_csa_adder #(.N(32), .SEG(8))  u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  pipe_csa_adder #(.N(16), .SEG(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  pipe_csa_adder #(.N(12), .SEG(4))  u_dut12 (.clk(clk), .rst_n(rst_n), .bus(bus12));

  // Behavioural reference: a + bb + c0 at width w, overflow from operand/result signs.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sub);
    longint unsigned mask, aa, bv, t;
    exp_t r;
    mask  = (64'd1 << w) - 64'd1;
    aa    = {32'd0, a} & mask;
    bv    = {32'd0, (sub ? ~b : b)} & mask;
    t     = aa + bv + ((sub ? ~ci : ci) ? 64'd1 : 64'd0);
    r.sum = 32'(t & mask);
    r.co  = t[w];
    r.ovf = (aa[w-1] == bv[w-1]) && (t[w-1] != aa[w-1]);
    return r;
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_7FFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Scoreboard step for DUT id: pop/compare on an output transfer, push on an input transfer.
  task automatic observe(input int id, input logic iv, input logic ir, input logic ov,
                         input logic ordy, input logic [31:0] s, input logic c, input logic o,
                         input exp_t e);
    exp_t x;
    int   sz;
    if (ov && ordy) begin
      case (id)
        0:       sz = q0.size();
        1:       sz = q1.size();
        default: sz = q2.size();
      endcase
      chk($sformatf("dut%0d output expected", id), (sz != 0), 1);
      if (sz != 0) begin
        case (id)
          0:       x = q0.pop_front();
          1:       x = q1.pop_front();
          default: x = q2.pop_front();
        endcase
        chk($sformatf("dut%0d sum", id), s, x.sum);
        chk($sformatf("dut%0d co", id), c, x.co);
        chk($sformatf("dut%0d ovf", id), o, x.ovf);
      end
    end
    if (iv && ir) begin
      case (id)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  // One cycle on the 32-bit unit: drive after the falling edge, sample 1 unit later.
  task automatic cyc32(input logic iv, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic sub, input logic ordy, input exp_t e,
                       output logic acc, output logic pop);
    @(negedge clk);
    bus32.in_valid  = iv;
    bus32.a         = a;
    bus32.b         = b;
    bus32.ci        = ci;
    bus32.sub       = sub;
    bus32.out_ready = ordy;
    #1;
    acc = iv & bus32.in_ready;
    pop = bus32.out_valid & ordy;
    observe(0, iv, bus32.in_ready, bus32.out_valid, ordy, bus32.sum, bus32.co, bus32.ovf, e);
  endtask

  // One random cycle on all three units with independent handshakes.
  task automatic rcyc(input logic active);
    @(negedge clk);
    bus32.in_valid  = active && ($urandom_range(3) != 0);
    bus32.a = rnd_op(); bus32.b = rnd_op();
    bus32.ci = 1'($urandom_range(1)); bus32.sub = 1'($urandom_range(1));
    bus32.out_ready = !active || ($urandom_range(3) != 0);
    bus16.in_valid  = active && ($urandom_range(3) != 0);
    bus16.a = 16'(rnd_op()); bus16.b = 16'(rnd_op());
    bus16.ci = 1'($urandom_range(1)); bus16.sub = 1'($urandom_range(1));
    bus16.out_ready = !active || ($urandom_range(3) != 0);
    bus12.in_valid  = active && ($urandom_range(3) != 0);
    bus12.a = 12'(rnd_op()); bus12.b = 12'(rnd_op());
    bus12.ci = 1'($urandom_range(1)); bus12.sub = 1'($urandom_range(1));
    bus12.out_ready = !active || ($urandom_range(3) != 0);
    #1;
    observe(0, bus32.in_valid, bus32.in_ready, bus32.out_valid, bus32.out_ready,
            bus32.sum, bus32.co, bus32.ovf,
            model(32, bus32.a, bus32.b, bus32.ci, bus32.sub));
    observe(1, bus16.in_valid, bus16.in_ready, bus16.out_valid, bus16.out_ready,
            {16'd0, bus16.sum}, bus16.co, bus16.ovf,
            model(16, {16'd0, bus16.a}, {16'd0, bus16.b}, bus16.ci, bus16.sub));
    observe(2, bus12.in_valid, bus12.in_ready, bus12.out_valid, bus12.out_ready,
            {20'd0, bus12.sum}, bus12.co, bus12.ovf,
            model(12, {20'd0, bus12.a}, {20'd0, bus12.b}, bus12.ci, bus12.sub));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tab[10];
    exp_t        e;
    exp_t        e0;
    logic        acc, pop, got, ir_last;
    int          cnt, first, last, npop, nacc;
    logic [31:0] a, b, held_sum;
    logic        held_co, held_ovf;

    tab[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0000_0000, 1'b1, 1'b0};
    tab[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 32'h8000_0000, 1'b0, 1'b1};
    tab[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, OP_SUB, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tab[3] = '{32'h0000_0007, 32'h0000_0005, 1'b1, OP_SUB, 32'h0000_0001, 1'b1, 1'b0};
    tab[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, OP_SUB, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tab[5] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b1, OP_ADD, 32'hACF1_3569, 1'b0, 1'b0};
    tab[6] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, OP_ADD, 32'h0000_0100, 1'b0, 1'b0};
    tab[7] = '{32'h00FF_FFFF, 32'h0000_0000, 1'b1, OP_ADD, 32'h0100_0000, 1'b0, 1'b0};
    tab[8] = '{32'h0000_0000, 32'h0000_0000, 1'b0, OP_SUB, 32'h0000_0000, 1'b1, 1'b0};
    tab[9] = '{32'h0000_0000, 32'h0000_0000, 1'b1, OP_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0};
    e0 = '{32'h0, 1'b0, 1'b0};

    rst_n = 1'b0;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.ci = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.ci = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b0;
    bus12.in_valid = 1'b0; bus12.a = '0; bus12.b = '0; bus12.ci = 1'b0; bus12.sub = 1'b0; bus12.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset out_valid", bus32.out_valid, 0);
    chk("reset in_ready", bus32.in_ready, 1);
    chk("reset sum", bus32.sum, 0);
    chk("reset co", bus32.co, 0);
    chk("reset ovf", bus32.ovf, 0);

    // Directed table, one transaction at a time; each must appear 4 cycles after accept.
    for (int i = 0; i < 10; i++) begin
      e = '{tab[i].sum, tab[i].co, tab[i].ovf};
      cyc32(1'b1, tab[i].a, tab[i].b, tab[i].ci, tab[i].sub, 1'b1, e, acc, pop);
      chk($sformatf("table[%0d] accept", i), acc, 1);
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 16) begin
        cyc32(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e0, acc, pop);
        cnt++;
        if (pop) got = 1'b1;
      end
      chk($sformatf("table[%0d] latency", i), cnt, 4);
    end

    // Back-to-back stream: in_ready stays high and results emerge on consecutive cycles.
    first = -1; last = -1; npop = 0;
    for (int i = 0; i < 16; i++) begin
      a = 32'h1111_1111 * (i + 1);
      b = $urandom();
      e = model(32, a, b, 1'(i), 1'(i >> 1));
      cyc32(i < 8, a, b, 1'(i), 1'(i >> 1), 1'b1, e, acc, pop);
      if (i < 8) chk($sformatf("b2b in_ready[%0d]", i), acc, 1);
      if (pop) begin
        if (first < 0) first = i;
        last = i;
        npop++;
      end
    end
    chk("b2b result count", npop, 8);
    chk("b2b consecutive", last - first, 7);

    // Backpressure: 6 stalled cycles fill the pipe to 4 and freeze the output.
    nacc = 0; ir_last = 1'b1;
    held_sum = '0; held_co = 1'b0; held_ovf = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = $urandom(); b = $urandom();
      e = model(32, a, b, 1'b0, 1'b0);
      cyc32(1'b1, a, b, 1'b0, 1'b0, 1'b0, e, acc, pop);
      if (acc) nacc++;
      ir_last = bus32.in_ready;
      if (i == 4) begin
        chk("stall out_valid", bus32.out_valid, 1);
        held_sum = bus32.sum; held_co = bus32.co; held_ovf = bus32.ovf;
      end
      if (i == 5) begin
        chk("stall sum stable", bus32.sum, held_sum);
        chk("stall co stable", bus32.co, held_co);
        chk("stall ovf stable", bus32.ovf, held_ovf);
        chk("stall out_valid held", bus32.out_valid, 1);
      end
    end
    chk("stall accepts", nacc, 4);
    chk("stall in_ready low", ir_last, 0);

    // Full pipe: a pop and a push in the same cycle both transfer.
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    e = model(32, a, b, 1'b1, 1'b1);
    cyc32(1'b1, a, b, 1'b1, 1'b1, 1'b1, e, acc, pop);
    chk("full push", acc, 1);
    chk("full pop", pop, 1);
    npop = 1;
    for (int i = 0; i < 12; i++) begin
      cyc32(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e0, acc, pop);
      if (pop) npop++;
    end
    chk("release result count", npop, 5);
    chk("release queue empty", q0.size(), 0);

    // Reset with three transactions in flight: nothing may emerge afterwards.
    for (int i = 0; i < 3; i++) begin
      a = $urandom(); b = $urandom();
      e = model(32, a, b, 1'b0, 1'b0);
      cyc32(1'b1, a, b, 1'b0, 1'b0, 1'b1, e, acc, pop);
    end
    @(negedge clk);
    rst_n = 1'b0;
    bus32.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("flush out_valid", bus32.out_valid, 0);
    chk("flush in_ready", bus32.in_ready, 1);
    q0.delete();
    npop = 0;
    for (int i = 0; i < 8; i++) begin
      cyc32(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, e0, acc, pop);
      if (pop) npop++;
    end
    chk("flush no stale output", npop, 0);

    // Constrained-random traffic on all three configurations, then drain.
    for (int i = 0; i < 14000; i++) rcyc(1'b1);
    for (int i = 0; i < 20; i++) rcyc(1'b0);
    chk("random dut0 drained", q0.size(), 0);
    chk("random dut1 drained", q1.size(), 0);
    chk("random dut2 drained", q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
